// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, size limits and the parity helper
// used by the transmit engine (and later by the receiver).
package uart_pkg;

  localparam int UART_DATA_W_MAX = 9;
  localparam int UART_OVS_MAX    = 16;
  localparam int UART_TICK_W     = $clog2(UART_OVS_MAX);
  localparam int UART_BIT_W      = $clog2(UART_DATA_W_MAX);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity when odd==0; narrower words are zero-extended by the caller.
  function automatic logic uart_parity(input logic [UART_DATA_W_MAX-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversampling tick counter: counts baud strobes modulo OVS and flags the
// strobe that closes a bit period. Shared between transmitter and receiver.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int OVS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic bclk_i,
  output logic bit_end_o
);

  logic [UART_TICK_W-1:0] tick_q;
  logic [UART_TICK_W-1:0] tick_d;
  logic                   last_s;

  assign last_s    = (tick_q == UART_TICK_W'(OVS - 1));
  assign bit_end_o = bclk_i && !clr_i && last_s;

  // Next tick: clear has priority, wrap at the bit boundary.
  always_comb begin
    tick_d = tick_q;
    if (clr_i) begin
      tick_d = '0;
    end else if (bclk_i) begin
      tick_d = last_s ? '0 : tick_q + UART_TICK_W'(1);
    end else begin
      tick_d = tick_q;
    end
  end

  // Tick register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit engine: one-entry holding register, shift register, frame FSM
// and registered TXD. Back-to-back words load at the final stop boundary.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OVS    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bclk,
  input  logic              tx_en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              cfg_par_en,
  input  logic              cfg_par_odd,
  input  logic              cfg_stop2,
  output logic              tx_data,
  output logic              busy,
  output logic              done
);

  uart_state_e           state_q, state_d;
  logic [DATA_W-1:0]     hold_q, hold_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic                  hold_full_q, hold_full_d;
  logic [UART_BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  par_q, par_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  bit_end_s;
  logic                  timer_clr_s;
  logic                  accept_s;
  logic                  final_stop_s;
  logic                  load_s;

  // Timer is held at zero in IDLE so the load strobe itself is not counted.
  assign timer_clr_s = (state_q == ST_IDLE);

  uart_bit_timer #(.OVS(OVS)) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (timer_clr_s),
    .bclk_i    (bclk),
    .bit_end_o (bit_end_s)
  );

  assign accept_s     = s_valid && !hold_full_q;
  assign final_stop_s = (state_q == ST_STOP) && bit_end_s && (!stop2_q || stop_cnt_q);
  assign load_s       = bclk && hold_full_q && tx_en && ((state_q == ST_IDLE) || final_stop_s);

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    par_en_d    = par_en_q;
    par_d       = par_q;
    stop2_d     = stop2_q;
    tx_d        = tx_q;
    done_d      = 1'b0;

    if (load_s) begin
      hold_full_d = 1'b0;
    end else if (accept_s) begin
      hold_full_d = 1'b1;
      hold_d      = s_data;
    end else begin
      hold_full_d = hold_full_q;
    end

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          if (bit_cnt_q == UART_BIT_W'(DATA_W - 1)) begin
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d    = ST_STOP;
              stop_cnt_d = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + UART_BIT_W'(1);
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b1;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (final_stop_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          tx_d    = 1'b1;
        end else if (bit_end_s) begin
          stop_cnt_d = 1'b1;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // A load overrides the end-of-frame return to IDLE (zero-gap restart).
    if (load_s) begin
      state_d  = ST_START;
      shift_d  = hold_q;
      par_en_d = cfg_par_en;
      par_d    = uart_parity(UART_DATA_W_MAX'(hold_q), cfg_par_odd);
      stop2_d  = cfg_stop2;
      tx_d     = 1'b0;
    end else begin
      par_en_d = par_en_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      par_en_q    <= 1'b0;
      par_q       <= 1'b0;
      stop2_q     <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      par_en_q    <= par_en_d;
      par_q       <= par_d;
      stop2_q     <= stop2_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
    end
  end

  assign tx_data = tx_q;
  assign done    = done_q;
  assign busy    = (state_q != ST_IDLE);
  assign s_ready = !hold_full_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: expected frames are queued on accept and
// a monitor checks the line strobe by strobe against a bit-list reference.
module tb_uart_tx_frame;

  localparam int DATA_W = 8;
  localparam int OVS    = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              bclk = 1'b0;
  logic              tx_en = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              cfg_par_en = 1'b0;
  logic              cfg_par_odd = 1'b0;
  logic              cfg_stop2 = 1'b0;
  logic              tx_data;
  logic              busy;
  logic              done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [15:0] bits;
    int          len;
    int          acc_cyc;
  } frame_t;

  frame_t exp_q[$];

  uart_tx_frame #(.DATA_W(DATA_W), .OVS(OVS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bclk        (bclk),
    .tx_en       (tx_en),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .cfg_par_en  (cfg_par_en),
    .cfg_par_odd (cfg_par_odd),
    .cfg_stop2   (cfg_stop2),
    .tx_data     (tx_data),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // One-clk baud strobes with a random 1..2 cycle gap.
  initial begin
    forever begin
      repeat ($urandom_range(1, 2)) begin
        @(posedge clk);
        #1 bclk = 1'b0;
      end
      @(posedge clk);
      #1 bclk = 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame as a list of line levels, one per bit period.
  function automatic frame_t make_frame(input logic [DATA_W-1:0] d, input bit pe,
                                        input bit po, input bit s2);
    frame_t f;
    int n;
    f.bits = '0;
    f.acc_cyc = 0;
    f.bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < DATA_W; i++) begin
      f.bits[n] = d[i];
      n++;
    end
    if (pe) begin
      f.bits[n] = (($countones(d) % 2) == 1) ^ po;
      n++;
    end
    f.bits[n] = 1'b1;
    n++;
    if (s2) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.len = n;
    return f;
  endfunction

  // Monitor: checks tx_data, busy and done at every falling edge.
  initial begin : monitor
    logic   se;
    logic   en;
    bit     in_frame;
    bit     exp_done;
    bit     exp_start;
    int     idx;
    frame_t cur;
    in_frame = 1'b0;
    idx = 0;
    cur.bits = '0;
    cur.len = 0;
    cur.acc_cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      se = bclk;
      en = tx_en;
      @(negedge clk);
      if (!mon_en) begin
        in_frame = 1'b0;
      end else begin
        exp_done = 1'b0;
        if (se && in_frame) begin
          idx++;
          if (idx == cur.len * OVS) begin
            in_frame = 1'b0;
            exp_done = 1'b1;
          end
        end
        if (se && !in_frame) begin
          exp_start = en && (exp_q.size() > 0) && (exp_q[0].acc_cyc < cyc);
          if (exp_start) begin
            cur = exp_q.pop_front();
            idx = 0;
            in_frame = 1'b1;
          end
        end
        chk("tx_data", 32'(tx_data), in_frame ? 32'(cur.bits[idx / OVS]) : 32'd1);
        chk("busy", 32'(busy), 32'(in_frame));
        chk("done", 32'(done), 32'(exp_done));
      end
    end
  end

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (s_ready !== 1'b1 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(s_ready), 32'd1);
  endtask

  task automatic submit(input logic [DATA_W-1:0] d, input bit pe, input bit po,
                        input bit s2, input bit wait_load);
    frame_t f;
    wait_ready("ready_before_accept");
    cfg_par_en  = pe;
    cfg_par_odd = po;
    cfg_stop2   = s2;
    s_data      = d;
    s_valid     = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
    f = make_frame(d, pe, po, s2);
    f.acc_cyc = cyc;
    exp_q.push_back(f);
    chk("s_ready_after_accept", 32'(s_ready), 32'd0);
    if (wait_load) wait_ready("load_within_budget");
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy !== 1'b0 || s_ready !== 1'b1) && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_within_budget", 32'(busy), 32'd0);
  endtask

  task automatic wait_not_busy();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("frame_end_within_budget", 32'(busy), 32'd0);
  endtask

  task automatic wait_strobes(input int k);
    int n;
    n = 0;
    while (n < k) begin
      @(posedge clk);
      if (bclk) n++;
    end
    #1;
  endtask

  // Stimulus.
  initial begin
    int gap;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_data", 32'(tx_data), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_s_ready", 32'(s_ready), 32'd1);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tx_en = 1'b1;

    // 8N1, 8E1, 8O2 with 0xA5
    submit(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle();
    submit(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_idle();
    submit(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_idle();

    // back-to-back
    submit(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    submit(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // disabled with hold full, then enable
    tx_en = 1'b0;
    submit(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_strobes(40);
    chk("hold_full_while_disabled", 32'(s_ready), 32'd0);
    chk("no_start_while_disabled", 32'(busy), 32'd0);
    tx_en = 1'b1;
    wait_strobes(1);
    chk("start_on_next_strobe_busy", 32'(busy), 32'd1);
    chk("start_on_next_strobe_tx", 32'(tx_data), 32'd0);
    wait_idle();

    // drop tx_en mid-frame with a word waiting
    submit(8'hC3, 1'b0, 1'b0, 1'b1, 1'b1);
    submit(8'h81, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_strobes(3 * OVS);
    tx_en = 1'b0;
    wait_not_busy();
    wait_strobes(OVS);
    chk("held_word_kept", 32'(s_ready), 32'd0);
    chk("idle_after_disable", 32'(busy), 32'd0);
    tx_en = 1'b1;
    wait_idle();

    // randomized traffic, config changing between queued words
    for (int i = 0; i < 24; i++) begin
      submit(DATA_W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        gap = $urandom_range(0, 30);
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
    end
    wait_idle();

    // reset during data bit 3
    submit(8'hB6, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_strobes(4 * OVS + 5);
    mon_en = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_tx_data", 32'(tx_data), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_s_ready", 32'(s_ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("no_done_after_abort", 32'(done), 32'd0);
    end
    mon_en = 1'b1;

    submit(8'h5A, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_idle();
    wait_strobes(4);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmit engine: serialises words of configurable width with runtime-selectable parity and 1/2 stop bits, timed from an oversampled baud strobe. It sits between the APB register block (TX data/config registers) and the TXD pin. A one-entry holding register with a valid/ready handshake lets software queue the next word during a frame, so back-to-back frames have no idle gap.

## Interface
- `DATA_W`, default 8: data bits per frame; legal values 5..9.
- `OVS`, default 16: `bclk` strobes per bit period; legal values 4..16.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `bclk` in 1: one-`clk`-wide baud strobe at `OVS` × baud rate.
- `tx_en` in 1: transmitter enable; gates frame start only.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: the holding register is empty.
- `s_data` in `DATA_W`: word to send.
- `cfg_par_en` in 1: append a parity bit.
- `cfg_par_odd` in 1: 1 selects odd parity, 0 selects even.
- `cfg_stop2` in 1: 1 selects two stop bits, 0 selects one.
- `tx_data` out 1: serial line; idles high.
- `busy` out 1: a frame is in progress (not IDLE).
- `done` out 1: one-`clk` pulse when a frame's final stop bit ends.

## Operation
- Reset values: `tx_data`=1, `busy`=0, `done`=0, `s_ready`=1. The holding register is empty, the FSM is in IDLE, and the tick and bit counters are 0.
- Handshake: a word is accepted on any `clk` where `s_valid && s_ready`. `s_ready` = !hold_full. The holding register fills on accept and empties when the FSM loads it into the shift register.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE → START on the first `bclk` where hold_full && `tx_en`.
  - On that edge, load shift reg ← hold and empty hold.
  - Latch `cfg_par_en`, `cfg_par_odd` and `cfg_stop2` for the whole frame.
  - Compute parity = ^data ^ cfg_par_odd.
  - Drive `tx_data` to 0.
- Each bit lasts exactly `OVS` `bclk` strobes. The tick counter runs 0..OVS-1, and the bit boundary is the strobe with tick==OVS-1.
- DATA sends LSB first, `DATA_W` bits, tracked by a bit counter 0..DATA_W-1.
  - If the latched par_en is 1, go to PARITY; otherwise go to STOP.
- PARITY: one bit equal to the latched parity value.
- STOP: `tx_data`=1 for 1 bit, or 2 bits if the latched stop2 is 1.
- At the final stop boundary, pulse `done` for one `clk`. Then:
  - If hold_full && `tx_en`, go directly to START, applying the same load rules as from IDLE (zero-gap back-to-back).
  - Otherwise go to IDLE.
- `tx_en` deasserted mid-frame: the current frame completes and no new frame starts. The hold contents are kept.
- Accept and load on the same `clk` (hold full, FSM loads, `s_valid` high): `s_ready` is 0 that cycle, so there is no accept. The hold accepts on the next cycle.
- Config inputs changing mid-frame have no effect until the next load.
- `bclk` is ignored in IDLE unless a start is pending. Strobes arriving with no pending start do not advance the tick counter.

## Timing
- Start latency: `tx_data` falls on the clock edge of the first qualifying `bclk` after hold_full && `tx_en`.
- Frame length = OVS × (1 + DATA_W + par_en + 1 + stop2) strobes.
- `busy` rises with the start bit and falls on the edge after the final stop boundary, unless a back-to-back frame starts there.
- `done` is asserted in the `clk` cycle following the final stop-bit strobe.
- `rst_n` low mid-frame: on the next edge, `tx_data`=1, the frame is aborted and the hold is cleared. No `done` pulse.
- `tx_data` is registered with no combinational path from inputs.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3 bits).
  - `UART_DATA_W_MAX`=9 and `UART_OVS_MAX`=16 constants.
  - A parity-function helper.
- Sub-module `uart_bit_timer`:
  - Counts `bclk` strobes modulo `OVS`.
  - Clear input plus a `bit_end` pulse output.
  - Reused by the future receiver.
- The top level contains the holding register, shift register, FSM and output register.

## Test plan
- 8N1, OVS=16, send 0xA5 with `tx_en`=1 → `tx_data` = 0,1,0,1,0,0,1,0,1,1, each bit held 16 strobes. 160 strobes total; one `done` pulse.
- 8E1, send 0xA5 → parity bit 0. 8O2, send 0xA5 → parity bit 1, followed by two stop bits. Frame lengths 176 and 192 strobes.
- Back-to-back: queue 0x55 then 0x0F while busy → no idle bit between the frames. `s_ready` goes low after the second accept and high on the second load. Two `done` pulses.
- `tx_en`=0 with the hold full → no start, and `s_ready` stays 0. Raise `tx_en` → start on the next strobe. Drop `tx_en` mid-frame → the frame completes, then IDLE.
- Assert `rst_n`=0 during DATA bit 3 → next edge `tx_data`=1, `busy`=0, `s_ready`=1, no `done` pulse.
- Change `cfg_par_en` mid-frame → the current frame is unaffected, and the next frame uses the new setting.
